// File: rtl/tlu_pkg.sv
// Shared types and constants for the TLU trigger scheduler.
package tlu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_FIRE,
        ST_WAIT_READY,
        ST_DEAD
    } state_e;

    localparam int          READY_HOLD_CYC  = 2;
    localparam logic [7:0]  TIMEOUT_CNT_MAX = 8'hFF;

endpackage

// File: rtl/tlu_sat_counter.sv
// Generic event counter with synchronous clear; either wraps or saturates at MAX_VAL.
module tlu_sat_counter #(
    parameter int               WIDTH    = 8,
    parameter bit               SATURATE = 1'b0,
    parameter logic [WIDTH-1:0] MAX_VAL  = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !(SATURATE && (count_q == MAX_VAL))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tlu_trig_scheduler.sv
// Trigger scheduler: gates trigger requests against DUT readiness, FIFO space, run state,
// dead time and trigger budget, and issues registered one-cycle TRIG_GO/EVT_WRITE pulses.
module tlu_trig_scheduler
    import tlu_pkg::*;
#(
    parameter int N_DUT          = 6,
    parameter int TRIG_ID_WIDTH  = 32,
    parameter int SKIP_CNT_WIDTH = 32
) (
    input  logic                      SYS_CLK,
    input  logic                      SYS_RST_N,
    input  logic                      START,
    input  logic                      STOP,
    input  logic                      TRIG_REQ,
    input  logic [N_DUT-1:0]          CONF_EN_OUTPUT,
    input  logic [15:0]               CONF_DEAD_TIME,
    input  logic [15:0]               CONF_TIME_OUT,
    input  logic [TRIG_ID_WIDTH-1:0]  CONF_MAX_TRIGGERS,
    input  logic [N_DUT-1:0]          READY,
    input  logic                      EVT_FULL,
    output logic                      TRIG_GO,
    output logic                      EVT_WRITE,
    output logic [TRIG_ID_WIDTH-1:0]  TRIG_ID,
    output logic [SKIP_CNT_WIDTH-1:0] SKIP_CNT,
    output logic [7:0]                TIMEOUT_CNT,
    output logic                      ARMED,
    output logic                      DONE
);

    state_e                     state_q, state_d;
    logic [TRIG_ID_WIDTH-1:0]   issued_q, issued_d;
    logic [TRIG_ID_WIDTH-1:0]   trig_id_q, trig_id_d;
    logic [15:0]                wait_cnt_q, wait_cnt_d;
    logic [15:0]                dead_cnt_q, dead_cnt_d;
    logic                       done_q, done_d;
    logic                       trig_go_q, trig_go_d;
    logic                       armed_q, armed_d;

    logic all_rdy;
    logic start_only;
    logic req_live;
    logic accept;
    logic skip_inc;
    logic timeout_inc;
    logic budget_hit;
    logic ready_ok;
    logic wd_expired;
    logic finish;

    // Disabled channels count as ready, so an empty enable mask still issues triggers.
    assign all_rdy    = &(READY | ~CONF_EN_OUTPUT);
    assign start_only = START & ~STOP;
    assign req_live   = TRIG_REQ & ~START & ~STOP;
    assign accept     = (state_q == ST_ARMED) & req_live & all_rdy & ~EVT_FULL;
    assign skip_inc   = req_live & (state_q != ST_IDLE) & ~accept;
    assign budget_hit = (CONF_MAX_TRIGGERS != '0) && (issued_q == CONF_MAX_TRIGGERS);

    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        trig_id_d   = trig_id_q;
        wait_cnt_d  = wait_cnt_q;
        dead_cnt_d  = dead_cnt_q;
        done_d      = done_q;
        timeout_inc = 1'b0;
        finish      = 1'b0;
        ready_ok    = (wait_cnt_q >= 16'(READY_HOLD_CYC)) && all_rdy;
        wd_expired  = (CONF_TIME_OUT != 16'd0) && (wait_cnt_q == CONF_TIME_OUT - 16'd1);

        case (state_q)
            ST_ARMED: begin
                if (accept) begin
                    state_d   = ST_FIRE;
                    trig_id_d = issued_q;
                    issued_d  = issued_q + 1'b1;
                end
            end
            ST_FIRE: begin
                state_d    = ST_WAIT_READY;
                wait_cnt_d = '0;
            end
            ST_WAIT_READY: begin
                if (wait_cnt_q != 16'hFFFF) begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
                if (ready_ok || wd_expired) begin
                    timeout_inc = ~ready_ok & ~STOP;
                    if (CONF_DEAD_TIME == 16'd0) begin
                        finish = 1'b1;
                    end else begin
                        state_d    = ST_DEAD;
                        dead_cnt_d = '0;
                    end
                end
            end
            ST_DEAD: begin
                dead_cnt_d = dead_cnt_q + 16'd1;
                if ((CONF_DEAD_TIME == 16'd0) || (dead_cnt_q >= CONF_DEAD_TIME - 16'd1)) begin
                    finish = 1'b1;
                end
            end
            default: ;
        endcase

        if (finish) begin
            state_d = budget_hit ? ST_IDLE : ST_ARMED;
            if (budget_hit) begin
                done_d = 1'b1;
            end
        end

        // STOP has priority over START; only a lone START restarts the run.
        if (STOP) begin
            state_d = ST_IDLE;
        end else if (START) begin
            state_d   = ST_ARMED;
            issued_d  = '0;
            trig_id_d = '0;
            done_d    = 1'b0;
        end

        trig_go_d = (state_d == ST_FIRE);
        armed_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q    <= ST_IDLE;
            issued_q   <= '0;
            trig_id_q  <= '0;
            wait_cnt_q <= '0;
            dead_cnt_q <= '0;
            done_q     <= 1'b0;
            trig_go_q  <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            trig_id_q  <= trig_id_d;
            wait_cnt_q <= wait_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            done_q     <= done_d;
            trig_go_q  <= trig_go_d;
            armed_q    <= armed_d;
        end
    end

    tlu_sat_counter #(
        .WIDTH    (SKIP_CNT_WIDTH),
        .SATURATE (1'b0),
        .MAX_VAL  ({SKIP_CNT_WIDTH{1'b1}})
    ) u_skip_cnt (
        .clk   (SYS_CLK),
        .rst_n (SYS_RST_N),
        .clr   (start_only),
        .inc   (skip_inc),
        .count (SKIP_CNT)
    );

    tlu_sat_counter #(
        .WIDTH    (8),
        .SATURATE (1'b1),
        .MAX_VAL  (TIMEOUT_CNT_MAX)
    ) u_timeout_cnt (
        .clk   (SYS_CLK),
        .rst_n (SYS_RST_N),
        .clr   (start_only),
        .inc   (timeout_inc),
        .count (TIMEOUT_CNT)
    );

    assign TRIG_GO   = trig_go_q;
    assign EVT_WRITE = trig_go_q;
    assign TRIG_ID   = trig_id_q;
    assign ARMED     = armed_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_tlu_trig_scheduler.sv
// Directed self-checking bench for tlu_trig_scheduler with a trigger-ID scoreboard.
module tb_tlu_trig_scheduler;

    logic        SYS_CLK = 1'b0;
    logic        SYS_RST_N;
    logic        START, STOP, TRIG_REQ, EVT_FULL;
    logic [5:0]  CONF_EN_OUTPUT, READY;
    logic [15:0] CONF_DEAD_TIME, CONF_TIME_OUT;
    logic [31:0] CONF_MAX_TRIGGERS;
    logic        TRIG_GO, EVT_WRITE, ARMED, DONE;
    logic [31:0] TRIG_ID, SKIP_CNT;
    logic [7:0]  TIMEOUT_CNT;

    int          checks   = 0;
    int          errors   = 0;
    int          go_count = 0;
    int          go_before;
    logic [31:0] exp_q[$];

    tlu_trig_scheduler dut (
        .SYS_CLK           (SYS_CLK),
        .SYS_RST_N         (SYS_RST_N),
        .START             (START),
        .STOP              (STOP),
        .TRIG_REQ          (TRIG_REQ),
        .CONF_EN_OUTPUT    (CONF_EN_OUTPUT),
        .CONF_DEAD_TIME    (CONF_DEAD_TIME),
        .CONF_TIME_OUT     (CONF_TIME_OUT),
        .CONF_MAX_TRIGGERS (CONF_MAX_TRIGGERS),
        .READY             (READY),
        .EVT_FULL          (EVT_FULL),
        .TRIG_GO           (TRIG_GO),
        .EVT_WRITE         (EVT_WRITE),
        .TRIG_ID           (TRIG_ID),
        .SKIP_CNT          (SKIP_CNT),
        .TIMEOUT_CNT       (TIMEOUT_CNT),
        .ARMED             (ARMED),
        .DONE              (DONE)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge SYS_CLK);
        #1;
    endtask

    task automatic pulse_req();
        TRIG_REQ = 1'b1;
        tick(1);
        TRIG_REQ = 1'b0;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick(1);
        START = 1'b0;
    endtask

    // Every trigger pulse must pop the ID the stimulus predicted when it drove the request.
    always @(negedge SYS_CLK) begin
        if (SYS_RST_N && (TRIG_GO || EVT_WRITE)) begin
            check_output("evt_write_with_go", {31'd0, EVT_WRITE}, {31'd0, TRIG_GO});
            if (TRIG_GO) begin
                go_count++;
                if (exp_q.size() == 0) begin
                    check_output("unexpected_trig_go", {31'd0, TRIG_GO}, 32'd0);
                end else begin
                    check_output("scoreboard_trig_id", TRIG_ID, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        SYS_RST_N = 1'b0;
        START = 1'b0; STOP = 1'b0; TRIG_REQ = 1'b0; EVT_FULL = 1'b0;
        CONF_EN_OUTPUT = 6'h3F; READY = 6'h3F;
        CONF_DEAD_TIME = 16'd0; CONF_TIME_OUT = 16'd0; CONF_MAX_TRIGGERS = 32'd0;
        tick(3);
        check_output("rst_trig_go", {31'd0, TRIG_GO}, 32'd0);
        check_output("rst_evt_write", {31'd0, EVT_WRITE}, 32'd0);
        check_output("rst_trig_id", TRIG_ID, 32'd0);
        check_output("rst_skip_cnt", SKIP_CNT, 32'd0);
        check_output("rst_timeout_cnt", {24'd0, TIMEOUT_CNT}, 32'd0);
        check_output("rst_armed", {31'd0, ARMED}, 32'd0);
        check_output("rst_done", {31'd0, DONE}, 32'd0);
        SYS_RST_N = 1'b1;
        tick(1);

        // Basic issue: IDLE ignores requests, then two accepted triggers.
        pulse_req();
        check_output("idle_req_not_counted", SKIP_CNT, 32'd0);
        check_output("idle_not_armed", {31'd0, ARMED}, 32'd0);
        pulse_start();
        check_output("start_armed", {31'd0, ARMED}, 32'd1);
        exp_q.push_back(32'd0);
        pulse_req();
        check_output("latency_trig_go", {31'd0, TRIG_GO}, 32'd1);
        check_output("first_trig_id", TRIG_ID, 32'd0);
        tick(6);
        exp_q.push_back(32'd1);
        pulse_req();
        check_output("second_trig_id", TRIG_ID, 32'd1);
        tick(6);

        // Dead time 10: requests during WAIT_READY and DEAD are skipped, last DEAD cycle too.
        CONF_DEAD_TIME = 16'd10;
        pulse_start();
        check_output("restart_trig_id", TRIG_ID, 32'd0);
        exp_q.push_back(32'd0);
        pulse_req();
        tick(2);
        pulse_req();
        tick(2);
        pulse_req();
        check_output("dead_skip_cnt", SKIP_CNT, 32'd2);
        tick(7);
        pulse_req();
        check_output("dead_last_cycle_skip", SKIP_CNT, 32'd3);
        exp_q.push_back(32'd1);
        pulse_req();
        check_output("after_dead_trig_go", {31'd0, TRIG_GO}, 32'd1);
        tick(20);
        CONF_DEAD_TIME = 16'd0;

        // Watchdog: channel 1 never returns READY.
        CONF_EN_OUTPUT = 6'b000011;
        CONF_TIME_OUT  = 16'd20;
        pulse_start();
        exp_q.push_back(32'd0);
        pulse_req();
        READY = 6'b111101;
        tick(20);
        check_output("timeout_not_yet", {24'd0, TIMEOUT_CNT}, 32'd0);
        tick(1);
        check_output("timeout_cnt", {24'd0, TIMEOUT_CNT}, 32'd1);
        check_output("timeout_rearmed", {31'd0, ARMED}, 32'd1);
        pulse_req();
        check_output("not_ready_skip", SKIP_CNT, 32'd1);
        check_output("not_ready_no_go", {31'd0, TRIG_GO}, 32'd0);
        READY = 6'h3F;
        CONF_EN_OUTPUT = 6'h3F;
        CONF_TIME_OUT = 16'd0;
        tick(2);

        // Event FIFO full blocks the request.
        pulse_start();
        check_output("start_clears_timeout", {24'd0, TIMEOUT_CNT}, 32'd0);
        EVT_FULL = 1'b1;
        pulse_req();
        EVT_FULL = 1'b0;
        check_output("full_no_go", {31'd0, TRIG_GO}, 32'd0);
        check_output("full_skip", SKIP_CNT, 32'd1);
        exp_q.push_back(32'd0);
        pulse_req();
        check_output("after_full_go", {31'd0, TRIG_GO}, 32'd1);
        tick(6);

        // Budget of three triggers; later requests land in IDLE.
        CONF_MAX_TRIGGERS = 32'd3;
        pulse_start();
        go_before = go_count;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) exp_q.push_back(32'(i));
            pulse_req();
            tick(7);
        end
        check_output("budget_go_count", 32'(go_count - go_before), 32'd3);
        check_output("budget_done", {31'd0, DONE}, 32'd1);
        check_output("budget_not_armed", {31'd0, ARMED}, 32'd0);
        check_output("budget_no_skip", SKIP_CNT, 32'd0);
        check_output("budget_last_id", TRIG_ID, 32'd2);
        pulse_start();
        check_output("start_clears_done", {31'd0, DONE}, 32'd0);
        check_output("start_clears_id", TRIG_ID, 32'd0);
        check_output("start_rearms", {31'd0, ARMED}, 32'd1);
        CONF_MAX_TRIGGERS = 32'd0;

        // START+STOP together: STOP wins, nothing cleared, request ignored.
        exp_q.push_back(32'd0);
        pulse_req();
        tick(6);
        EVT_FULL = 1'b1;
        pulse_req();
        EVT_FULL = 1'b0;
        exp_q.push_back(32'd1);
        pulse_req();
        tick(6);
        START = 1'b1; STOP = 1'b1; TRIG_REQ = 1'b1;
        tick(1);
        START = 1'b0; STOP = 1'b0; TRIG_REQ = 1'b0;
        check_output("startstop_idle", {31'd0, ARMED}, 32'd0);
        check_output("startstop_skip_kept", SKIP_CNT, 32'd1);
        check_output("startstop_id_kept", TRIG_ID, 32'd1);
        check_output("startstop_no_go", {31'd0, TRIG_GO}, 32'd0);

        // Asynchronous reset while waiting for READY.
        pulse_start();
        exp_q.push_back(32'd0);
        pulse_req();
        tick(6);
        exp_q.push_back(32'd1);
        pulse_req();
        tick(1);
        check_output("wait_ready_armed", {31'd0, ARMED}, 32'd1);
        SYS_RST_N = 1'b0;
        #1;
        check_output("async_rst_armed", {31'd0, ARMED}, 32'd0);
        check_output("async_rst_trig_id", TRIG_ID, 32'd0);
        check_output("async_rst_trig_go", {31'd0, TRIG_GO}, 32'd0);
        check_output("async_rst_skip", SKIP_CNT, 32'd0);
        check_output("async_rst_done", {31'd0, DONE}, 32'd0);
        tick(2);
        SYS_RST_N = 1'b1;
        tick(2);

        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
